cnn_image_loader: RTL and testbench

Front end of the CNN inference core. Accepts a serial stream of pixels and assembles them into the flat 784-entry image array that the core reads in parallel. Holds the image stable for a fixed inference latency, then captures the core's class prediction. Returns the prediction to the requester over a valid/ready handshake.

---
 rtl/cnn_pkg.sv | 20 ++
 rtl/cnn_loader_fsm.sv | 114 +++++++++++
 rtl/cnn_image_loader.sv | 73 +++++++
 tb/tb_cnn_image_loader.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared constants and types for the CNN image loader front end.
package cnn_pkg;

  localparam int unsigned N_PIX     = 784;
  localparam int unsigned PIX_W     = 9;
  localparam int unsigned CLS_W     = 4;
  localparam int unsigned IMG_DIM   = 28;
  localparam int unsigned PIX_CNT_W = $clog2(N_PIX);

  typedef logic signed [PIX_W-1:0] pixel_t;
  typedef logic signed [CLS_W-1:0] class_t;

  typedef enum logic [1:0] {
    LOAD,
    DRAIN,
    WAIT,
    RESULT
  } loader_state_t;

endpackage

// File: rtl/cnn_loader_fsm.sv
// Loader control: frame counting, framing-error tracking, inference wait and result handshake.
module cnn_loader_fsm
  import cnn_pkg::*;
#(
  parameter int unsigned InferLat = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   s_valid_i,
  input  logic                   s_last_i,
  input  logic signed [CLS_W-1:0] predict_i,
  input  logic                   res_ready_i,
  output logic                   s_ready_o,
  output logic                   res_valid_o,
  output logic signed [CLS_W-1:0] res_class_o,
  output logic                   res_err_o,
  output logic                   busy_o,
  output logic                   wr_en_o,
  output logic                   clr_tail_o,
  output logic [PIX_CNT_W-1:0]   pix_cnt_o
);

  localparam int unsigned WaitCntW = $clog2(InferLat + 1);
  localparam logic [PIX_CNT_W-1:0] LastIdx = PIX_CNT_W'(N_PIX - 1);
  // The WAIT entry cycle lets image_out settle; InferLat counted cycles follow it.
  localparam logic [WaitCntW-1:0] WaitEnd = WaitCntW'(InferLat);

  loader_state_t            state_q;
  logic [PIX_CNT_W-1:0]     pix_cnt_q;
  logic [WaitCntW-1:0]      wait_cnt_q;
  logic                     err_q;
  logic                     s_ready_q;
  logic                     res_valid_q;
  logic signed [CLS_W-1:0]  res_class_q;
  logic                     res_err_q;
  logic                     accept;

  assign accept = s_valid_i && s_ready_q;

  // State, counters and registered handshake outputs.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= LOAD;
      pix_cnt_q   <= '0;
      wait_cnt_q  <= '0;
      err_q       <= 1'b0;
      s_ready_q   <= 1'b0;
      res_valid_q <= 1'b0;
      res_class_q <= '0;
      res_err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        LOAD: begin
          s_ready_q <= 1'b1;
          if (accept) begin
            if (pix_cnt_q == LastIdx) begin
              if (s_last_i) begin
                state_q   <= WAIT;
                s_ready_q <= 1'b0;
              end else begin
                // Frame overran: swallow the rest up to s_last.
                state_q <= DRAIN;
                err_q   <= 1'b1;
              end
            end else begin
              pix_cnt_q <= pix_cnt_q + PIX_CNT_W'(1);
              if (s_last_i) begin
                state_q   <= WAIT;
                s_ready_q <= 1'b0;
                err_q     <= 1'b1;
              end
            end
          end
        end
        DRAIN: begin
          if (accept && s_last_i) begin
            state_q   <= WAIT;
            s_ready_q <= 1'b0;
          end
        end
        WAIT: begin
          if (wait_cnt_q == WaitEnd) begin
            res_class_q <= predict_i;
            res_err_q   <= err_q;
            res_valid_q <= 1'b1;
            state_q     <= RESULT;
          end else begin
            wait_cnt_q <= wait_cnt_q + WaitCntW'(1);
          end
        end
        RESULT: begin
          if (res_ready_i) begin
            res_valid_q <= 1'b0;
            pix_cnt_q   <= '0;
            err_q       <= 1'b0;
            wait_cnt_q  <= '0;
            s_ready_q   <= 1'b1;
            state_q     <= LOAD;
          end
        end
      endcase
    end
  end

  assign s_ready_o   = s_ready_q;
  assign res_valid_o = res_valid_q;
  assign res_class_o = res_class_q;
  assign res_err_o   = res_err_q;
  assign busy_o      = (state_q != LOAD);
  assign pix_cnt_o   = pix_cnt_q;
  assign wr_en_o     = (state_q == LOAD) && accept;
  assign clr_tail_o  = wr_en_o && s_last_i && (pix_cnt_q != LastIdx);

endmodule

// File: rtl/cnn_image_loader.sv
// Serial pixel stream to parallel 784-entry image buffer, with result capture and handshake.
// Optional build macro IMG_CLAMP_EN: negative pixels are stored as zero while loading.
module cnn_image_loader
  import cnn_pkg::*;
#(
  parameter int unsigned INFER_LAT = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic signed [PIX_W-1:0] s_data,
  input  logic                    s_last,
  output logic signed [PIX_W-1:0] image_out [0:N_PIX-1],
  input  logic signed [CLS_W-1:0] predict_in,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic signed [CLS_W-1:0] res_class,
  output logic                    res_err,
  output logic                    busy
);

  logic                    wr_en;
  logic                    clr_tail;
  logic [PIX_CNT_W-1:0]    pix_cnt;
  logic signed [PIX_W-1:0] wr_data;

  cnn_loader_fsm #(
    .InferLat (INFER_LAT)
  ) u_fsm (
    .clk_i       (clk),
    .rst_ni      (rst),
    .s_valid_i   (s_valid),
    .s_last_i    (s_last),
    .predict_i   (predict_in),
    .res_ready_i (res_ready),
    .s_ready_o   (s_ready),
    .res_valid_o (res_valid),
    .res_class_o (res_class),
    .res_err_o   (res_err),
    .busy_o      (busy),
    .wr_en_o     (wr_en),
    .clr_tail_o  (clr_tail),
    .pix_cnt_o   (pix_cnt)
  );

  // Pixel value as stored in the buffer.
  always_comb begin
`ifdef IMG_CLAMP_EN
    wr_data = s_data[PIX_W-1] ? '0 : s_data;
`else
    wr_data = s_data;
`endif
  end

  // Image buffer: one indexed write per accept; early s_last also clears every later entry.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N_PIX; i++) begin
        image_out[i] <= '0;
      end
    end else if (wr_en) begin
      for (int i = 0; i < N_PIX; i++) begin
        if (PIX_CNT_W'(i) == pix_cnt) begin
          image_out[i] <= wr_data;
        end else if (clr_tail && (PIX_CNT_W'(i) > pix_cnt)) begin
          image_out[i] <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_cnn_image_loader.sv
// Directed and randomized bench for cnn_image_loader against a frame-level reference model.
module tb_cnn_image_loader;

  localparam int NPIX = 784;
  localparam int LAT  = 16;

  logic              clk;
  logic              rst;
  logic              s_valid;
  logic              s_ready;
  logic signed [8:0] s_data;
  logic              s_last;
  logic signed [8:0] image_out [0:NPIX-1];
  logic signed [3:0] predict_in;
  logic              res_valid;
  logic              res_ready;
  logic signed [3:0] res_class;
  logic              res_err;
  logic              busy;

  int checks = 0;
  int errors = 0;

  logic signed [8:0] src [0:799];

  cnn_image_loader #(
    .INFER_LAT (LAT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_last     (s_last),
    .image_out  (image_out),
    .predict_in (predict_in),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_class  (res_class),
    .res_err    (res_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Expected buffer entry after a frame of len pixels taken from src.
  function automatic logic signed [8:0] model_pix(input int i, input int len);
    logic signed [8:0] v;
    if (i >= len) return 9'sd0;
    v = src[i];
`ifdef IMG_CLAMP_EN
    if (v < 0) v = 9'sd0;
`endif
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one pixel and return once it has been accepted; waits counts stall cycles.
  task automatic push(input logic signed [8:0] d, input logic last, output int waits);
    waits   = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    while (s_ready !== 1'b1 && waits < 100) begin
      tick();
      waits++;
    end
    if (waits >= 100) begin
      checks++;
      errors++;
      $error("FAIL push_timeout: observed s_ready=%0b expected 1", s_ready);
    end
    tick();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send(input int first, input int count, input int len, input bit gaps,
                      output int stalls);
    int w;
    stalls = 0;
    for (int i = first; i < first + count; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) tick();
      push(src[i], i == len - 1, w);
      stalls += w;
    end
  endtask

  task automatic image_cmp(input string tag, input int len);
    int bad = 0;
    for (int i = 0; i < NPIX; i++) begin
      if (image_out[i] !== model_pix(i, len)) bad++;
    end
    check({tag, " image_mismatches"}, bad, 0);
  endtask

  // With res_ready high: latency, payload, buffer and the single-cycle valid pulse.
  task automatic expect_result(input string tag, input int len, input logic signed [3:0] cls);
    int n = 0;
    while (res_valid !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    check({tag, " latency"}, n, LAT + 1);
    check({tag, " class"}, res_class, cls);
    check({tag, " err"}, res_err, (len != NPIX));
    image_cmp(tag, len);
    tick();
    check({tag, " valid_pulse"}, res_valid, 1'b0);
    check({tag, " busy_after"}, busy, 1'b0);
    check({tag, " s_ready_after"}, s_ready, 1'b1);
  endtask

  initial begin
    int st;
    int bad;
    int len;
    logic signed [3:0] cls;

    rst        = 1'b0;
    s_valid    = 1'b0;
    s_data     = '0;
    s_last     = 1'b0;
    predict_in = 4'sd7;
    res_ready  = 1'b1;
    tick();
    tick();
    check("reset s_ready", s_ready, 1'b0);
    check("reset res_valid", res_valid, 1'b0);
    check("reset busy", busy, 1'b0);
    check("reset res_class", res_class, 0);
    check("reset res_err", res_err, 1'b0);
    image_cmp("reset", 0);
    rst = 1'b1;
    tick();
    check("s_ready after release", s_ready, 1'b1);

    // Normal frame with index-pattern pixels.
    for (int i = 0; i < NPIX; i++) src[i] = 9'(i % 256);
    send(0, NPIX, NPIX, 1'b0, st);
    expect_result("normal", NPIX, 4'sd7);
    check("normal last_entry", image_out[783], 9'sd15);

    // Early last after 100 pixels of value 5.
    for (int i = 0; i < 100; i++) src[i] = 9'sd5;
    predict_in = 4'sd3;
    send(0, 100, 100, 1'b0, st);
    expect_result("early", 100, 4'sd3);

    // Late last: 784 loaded, 6 drained.
    for (int i = 0; i < 790; i++) src[i] = 9'($urandom);
    predict_in = -4'sd2;
    send(0, NPIX, 790, 1'b1, st);
    check("late drain busy", busy, 1'b1);
    check("late drain s_ready", s_ready, 1'b1);
    send(NPIX, 6, 790, 1'b0, st);
    check("late drain stalls", st, 0);
    check("late s_ready after last", s_ready, 1'b0);
    expect_result("late", 790, -4'sd2);

    // Backpressure on the result with predict_in moving underneath.
    for (int i = 0; i < 10; i++) src[i] = 9'($urandom);
    predict_in = -4'sd3;
    res_ready  = 1'b0;
    send(0, 10, 10, 1'b1, st);
    st = 0;
    while (res_valid !== 1'b1 && st < 200) begin
      tick();
      st++;
    end
    check("bp latency", st, LAT + 1);
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      predict_in = 4'($urandom);
      tick();
      if (res_valid !== 1'b1 || res_class !== -4'sd3 || res_err !== 1'b1 || s_ready !== 1'b0)
        bad++;
    end
    check("bp stable_cycles_bad", bad, 0);
    res_ready = 1'b1;
    tick();
    check("bp valid_dropped", res_valid, 1'b0);
    check("bp load_resumed", s_ready, 1'b1);
    check("bp busy", busy, 1'b0);

    // Reset part way through a frame.
    for (int i = 0; i < NPIX; i++) src[i] = 9'($urandom);
    send(0, 300, NPIX, 1'b1, st);
    rst = 1'b0;
    tick();
    image_cmp("midreset", 0);
    check("midreset res_valid", res_valid, 1'b0);
    check("midreset busy", busy, 1'b0);
    check("midreset s_ready", s_ready, 1'b0);
    rst = 1'b1;
    tick();
    predict_in = 4'sd5;
    send(0, NPIX, NPIX, 1'b1, st);
    expect_result("after_reset", NPIX, 4'sd5);

    // Negative pixel handling.
    for (int i = 0; i < 50; i++) src[i] = 9'($urandom);
    src[0] = -9'sd37;
    predict_in = -4'sd8;
    send(0, 50, 50, 1'b0, st);
    expect_result("negative", 50, -4'sd8);
`ifdef IMG_CLAMP_EN
    check("negative entry0", image_out[0], 9'sd0);
`else
    check("negative entry0", image_out[0], -9'sd37);
`endif

    // Randomized frames: lengths short, exact and overlong.
    for (int f = 0; f < 4; f++) begin
      unique case (f % 3)
        0: len = $urandom_range(1, NPIX - 1);
        1: len = NPIX;
        default: len = $urandom_range(NPIX + 1, 799);
      endcase
      for (int i = 0; i < len; i++) src[i] = 9'($urandom);
      cls = 4'($urandom);
      predict_in = cls;
      send(0, len, len, 1'b1, st);
      expect_result($sformatf("rand%0d", f), len, cls);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
